// File: rtl/ram_arb2_rr.sv
// rtl/ram_arb2_rr.sv - two-master arbiter onto one req/ack/resp memory port with in-order read routing
module ram_arb2_rr #(
    parameter int MAX_OUTSTANDING = 4,
    parameter bit RR_EN           = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus0_req_i,
    input  logic        bus0_we_i,
    input  logic [31:0] bus0_addr_bi,
    input  logic [3:0]  bus0_be_bi,
    input  logic [31:0] bus0_wdata_bi,
    output logic        bus0_ack_o,
    output logic        bus0_resp_o,
    output logic [31:0] bus0_rdata_bo,
    input  logic        bus1_req_i,
    input  logic        bus1_we_i,
    input  logic [31:0] bus1_addr_bi,
    input  logic [3:0]  bus1_be_bi,
    input  logic [31:0] bus1_wdata_bi,
    output logic        bus1_ack_o,
    output logic        bus1_resp_o,
    output logic [31:0] bus1_rdata_bo,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_bo,
    output logic [3:0]  ram_be_bo,
    output logic [31:0] ram_wdata_bo,
    input  logic        ram_ack_i,
    input  logic        ram_resp_i,
    input  logic [31:0] ram_rdata_bi,
    output logic        err_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic          last_grant_q, last_grant_d;
    logic          lock_q, lock_d;
    logic          lock_idx_q, lock_idx_d;
    logic          fifo_q [MAX_OUTSTANDING];
    logic          fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic grant, req_g, full, empty, accept, push, pop, head;

    // Pick the granted master: frozen while a handshake is pending, otherwise RR or fixed priority
    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else if (bus0_req_i && bus1_req_i) begin
            grant = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            grant = bus1_req_i;
        end
    end

    // Memory-side mux, read back-pressure on the registered count, ack/resp routing
    always_comb begin
        req_g        = grant ? bus1_req_i    : bus0_req_i;
        ram_we_o     = grant ? bus1_we_i     : bus0_we_i;
        ram_addr_bo  = grant ? bus1_addr_bi  : bus0_addr_bi;
        ram_be_bo    = grant ? bus1_be_bi    : bus0_be_bi;
        ram_wdata_bo = grant ? bus1_wdata_bi : bus0_wdata_bi;
        full         = (count_q == CW'(MAX_OUTSTANDING));
        empty        = (count_q == '0);
        ram_req_o    = ~rst_i & req_g & (ram_we_o | ~full);
        accept       = ram_req_o & ram_ack_i;
        push         = accept & ~ram_we_o;
        pop          = ~rst_i & ram_resp_i & ~empty;
        head         = fifo_q[rd_ptr_q];
        bus0_ack_o   = accept & ~grant;
        bus1_ack_o   = accept & grant;
        bus0_resp_o  = pop & ~head;
        bus1_resp_o  = pop & head;
        bus0_rdata_bo = ram_rdata_bi;
        bus1_rdata_bo = ram_rdata_bi;
        err_o        = err_q;
    end

    // Next state: lock, last grant, read-ID FIFO and sticky error
    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q | (ram_resp_i & empty);
        if (accept) begin
            lock_d       = 1'b0;
            last_grant_d = grant;
        end else if (ram_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous reset; bus0 wins the first contended grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_idx_q   <= 1'b0;
            fifo_q       <= '{default: 1'b0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_ram_arb2_rr.sv
// tb/tb_ram_arb2_rr.sv - self-checking bench for ram_arb2_rr
module tb_ram_arb2_rr;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  be0, be1;
    logic        ram_ack, ram_resp;
    logic [31:0] ram_rdata;

    logic        ack0, resp0, ack1, resp1;
    logic [31:0] rdata0, rdata1;
    logic        ram_req, ram_we, err;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_be;

    logic        fp_ack0, fp_resp0, fp_ack1, fp_resp1;
    logic [31:0] fp_rdata0, fp_rdata1;
    logic        fp_req, fp_we, fp_err;
    logic [31:0] fp_addr, fp_wdata;
    logic [3:0]  fp_be;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ram_arb2_rr #(.MAX_OUTSTANDING(MAXO), .RR_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .bus0_req_i(r0), .bus0_we_i(w0), .bus0_addr_bi(a0), .bus0_be_bi(be0), .bus0_wdata_bi(d0),
        .bus0_ack_o(ack0), .bus0_resp_o(resp0), .bus0_rdata_bo(rdata0),
        .bus1_req_i(r1), .bus1_we_i(w1), .bus1_addr_bi(a1), .bus1_be_bi(be1), .bus1_wdata_bi(d1),
        .bus1_ack_o(ack1), .bus1_resp_o(resp1), .bus1_rdata_bo(rdata1),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_bo(ram_addr), .ram_be_bo(ram_be),
        .ram_wdata_bo(ram_wdata), .ram_ack_i(ram_ack), .ram_resp_i(ram_resp),
        .ram_rdata_bi(ram_rdata), .err_o(err)
    );

    ram_arb2_rr #(.MAX_OUTSTANDING(MAXO), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .bus0_req_i(r0), .bus0_we_i(w0), .bus0_addr_bi(a0), .bus0_be_bi(be0), .bus0_wdata_bi(d0),
        .bus0_ack_o(fp_ack0), .bus0_resp_o(fp_resp0), .bus0_rdata_bo(fp_rdata0),
        .bus1_req_i(r1), .bus1_we_i(w1), .bus1_addr_bi(a1), .bus1_be_bi(be1), .bus1_wdata_bi(d1),
        .bus1_ack_o(fp_ack1), .bus1_resp_o(fp_resp1), .bus1_rdata_bo(fp_rdata1),
        .ram_req_o(fp_req), .ram_we_o(fp_we), .ram_addr_bo(fp_addr), .ram_be_bo(fp_be),
        .ram_wdata_bo(fp_wdata), .ram_ack_i(ram_ack), .ram_resp_i(ram_resp),
        .ram_rdata_bi(ram_rdata), .err_o(fp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding read owners, last winner, pending-handshake owner
    int  idq[$];
    int  last_m  = 1;
    bit  lock_m  = 0;
    int  owner_m = 0;
    bit  err_m   = 0;

    always @(negedge clk) begin
        int g;
        bit rq, wg, exp_req, acc;
        bit e_ack0, e_ack1, e_resp0, e_resp1;
        if (lock_m)       g = owner_m;
        else if (r0 && r1) g = 1 - last_m;
        else              g = r1 ? 1 : 0;
        rq      = (g == 1) ? r1 : r0;
        wg      = (g == 1) ? w1 : w0;
        exp_req = !rst && rq && (wg || idq.size() < MAXO);
        acc     = exp_req && ram_ack;
        e_ack0  = acc && g == 0;
        e_ack1  = acc && g == 1;
        e_resp0 = !rst && ram_resp && idq.size() > 0 && idq[0] == 0;
        e_resp1 = !rst && ram_resp && idq.size() > 0 && idq[0] == 1;
        chk("ram_req", {31'd0, ram_req}, {31'd0, exp_req});
        chk("ack0", {31'd0, ack0}, {31'd0, e_ack0});
        chk("ack1", {31'd0, ack1}, {31'd0, e_ack1});
        chk("resp0", {31'd0, resp0}, {31'd0, e_resp0});
        chk("resp1", {31'd0, resp1}, {31'd0, e_resp1});
        chk("err", {31'd0, err}, {31'd0, err_m});
        chk("rdata0", rdata0, ram_rdata);
        chk("rdata1", rdata1, ram_rdata);
        if (exp_req) begin
            chk("ram_we", {31'd0, ram_we}, {31'd0, wg});
            chk("ram_addr", ram_addr, (g == 1) ? a1 : a0);
            chk("ram_be", {28'd0, ram_be}, {28'd0, ((g == 1) ? be1 : be0)});
            chk("ram_wdata", ram_wdata, (g == 1) ? d1 : d0);
        end
        if (rst) begin
            idq.delete();
            last_m = 1; lock_m = 0; owner_m = 0; err_m = 0;
        end else begin
            if (ram_resp) begin
                if (idq.size() > 0) void'(idq.pop_front());
                else err_m = 1;
            end
            if (acc) begin
                last_m = g;
                lock_m = 0;
                if (!wg) idq.push_back(g);
            end else if (exp_req) begin
                lock_m  = 1;
                owner_m = g;
            end
        end
    end

    task automatic idle();
        r0 = 0; w0 = 0; a0 = 32'h0; d0 = 32'h0; be0 = 4'hF;
        r1 = 0; w1 = 0; a1 = 32'h0; d1 = 32'h0; be1 = 4'hF;
        ram_ack = 0; ram_resp = 0; ram_rdata = 32'h0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; idle();
        nxt(); nxt();
        rst = 0;
    endtask

    initial begin
        logic e0, e1;
        rst = 1; idle();
        // requests during reset are suppressed
        r0 = 1; ram_ack = 1; ram_resp = 1;
        smp();
        chk("lit_rst_req", {31'd0, ram_req}, 32'd0);
        chk("lit_rst_ack0", {31'd0, ack0}, 32'd0);
        chk("lit_rst_resp0", {31'd0, resp0}, 32'd0);
        chk("lit_rst_err", {31'd0, err}, 32'd0);
        nxt();
        do_reset();

        // single master read
        r0 = 1; a0 = 32'h10; be0 = 4'h3; ram_ack = 1;
        smp();
        chk("lit_a_ack0", {31'd0, ack0}, 32'd1);
        chk("lit_a_ack1", {31'd0, ack1}, 32'd0);
        chk("lit_a_addr", ram_addr, 32'h10);
        nxt();
        idle(); ram_resp = 1; ram_rdata = 32'hCAFE0010;
        smp();
        chk("lit_a_resp0", {31'd0, resp0}, 32'd1);
        chk("lit_a_resp1", {31'd0, resp1}, 32'd0);
        chk("lit_a_rdata0", rdata0, 32'hCAFE0010);
        nxt(); idle();

        // round-robin contention
        do_reset();
        r0 = 1; a0 = 32'h100; r1 = 1; a1 = 32'h200; ram_ack = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            e0 = (i % 2 == 0); e1 = (i % 2 == 1);
            chk("lit_b_ack0", {31'd0, ack0}, {31'd0, e0});
            chk("lit_b_ack1", {31'd0, ack1}, {31'd0, e1});
            nxt();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            ram_resp = 1; ram_rdata = 32'hB000 + i;
            smp();
            e0 = (i % 2 == 0); e1 = (i % 2 == 1);
            chk("lit_b_resp0", {31'd0, resp0}, {31'd0, e0});
            chk("lit_b_resp1", {31'd0, resp1}, {31'd0, e1});
            nxt();
        end
        idle();

        // lock holds bus1 while its handshake is pending
        do_reset();
        r1 = 1; a1 = 32'h200;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin r0 = 1; a0 = 32'h100; end
            smp();
            chk("lit_c_addr_wait", ram_addr, 32'h200);
            chk("lit_c_ack1_wait", {31'd0, ack1}, 32'd0);
            nxt();
        end
        ram_ack = 1;
        smp();
        chk("lit_c_ack1", {31'd0, ack1}, 32'd1);
        chk("lit_c_addr", ram_addr, 32'h200);
        nxt();
        r1 = 0;
        smp();
        chk("lit_c_ack0", {31'd0, ack0}, 32'd1);
        chk("lit_c_addr0", ram_addr, 32'h100);
        nxt();
        idle(); ram_resp = 1;
        smp(); chk("lit_c_resp1", {31'd0, resp1}, 32'd1);
        nxt();
        smp(); chk("lit_c_resp0", {31'd0, resp0}, 32'd1);
        nxt(); idle();

        // FIFO full back-pressure; writes pass; push+pop same cycle
        do_reset();
        ram_ack = 1; r0 = 1;
        for (int i = 0; i < 4; i++) begin
            a0 = 32'(i * 4);
            smp(); chk("lit_d_fill_ack0", {31'd0, ack0}, 32'd1);
            nxt();
        end
        a0 = 32'h10;
        smp(); chk("lit_d_full_req", {31'd0, ram_req}, 32'd0);
        nxt();
        r1 = 1; w1 = 1; a1 = 32'h300; d1 = 32'h5A5A;
        smp();
        chk("lit_d_wr_req", {31'd0, ram_req}, 32'd1);
        chk("lit_d_wr_ack1", {31'd0, ack1}, 32'd1);
        nxt();
        r1 = 0; w1 = 0; ram_resp = 1; ram_rdata = 32'hD0;
        smp();
        chk("lit_d_pop_req", {31'd0, ram_req}, 32'd0);
        chk("lit_d_pop_resp0", {31'd0, resp0}, 32'd1);
        nxt();
        ram_resp = 0;
        smp(); chk("lit_d_after_ack0", {31'd0, ack0}, 32'd1);
        nxt();
        a0 = 32'h20; ram_resp = 1;
        smp(); chk("lit_d_full2_req", {31'd0, ram_req}, 32'd0);
        nxt();
        smp();
        chk("lit_d_pp_ack0", {31'd0, ack0}, 32'd1);
        chk("lit_d_pp_resp0", {31'd0, resp0}, 32'd1);
        nxt();
        r0 = 0; ram_ack = 0;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("lit_d_drain", {31'd0, resp0}, 32'd1);
            nxt();
        end
        idle();

        // fixed priority instance: bus0 always wins
        do_reset();
        r0 = 1; w0 = 1; a0 = 32'h40; r1 = 1; w1 = 1; a1 = 32'h80; ram_ack = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("lit_f_fp_ack0", {31'd0, fp_ack0}, 32'd1);
            chk("lit_f_fp_ack1", {31'd0, fp_ack1}, 32'd0);
            nxt();
        end
        idle();

        // unexpected response sets sticky error
        do_reset();
        ram_resp = 1;
        smp();
        chk("lit_e_resp0", {31'd0, resp0}, 32'd0);
        chk("lit_e_resp1", {31'd0, resp1}, 32'd0);
        nxt();
        ram_resp = 0;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("lit_e_err", {31'd0, err}, 32'd1);
            nxt();
        end
        rst = 1;
        nxt();
        smp(); chk("lit_e_err_clr", {31'd0, err}, 32'd0);
        nxt();
        rst = 0;
        nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
